// File: rtl/hazard_pkg.sv
// Shared opcode map, source/writer decode and shadow-entry types for hazard_sched.
// HAZARD_FORWARD_EN selects forwarding mode in the top; this package is the same for both builds.
package hazard_pkg;

  localparam int unsigned RegAw = 4;
  localparam int unsigned OpW   = 4;

  localparam logic [OpW-1:0] OpAluR   = 4'b1100;
  localparam logic [OpW-1:0] OpAluI   = 4'b0100;
  localparam logic [OpW-1:0] OpLw     = 4'b0111;
  localparam logic [OpW-1:0] OpSw     = 4'b0011;
  localparam logic [OpW-1:0] OpCmpR   = 4'b1101;
  localparam logic [OpW-1:0] OpCmpI   = 4'b0101;
  localparam logic [OpW-1:0] OpBranch = 4'b0010;
  localparam logic [OpW-1:0] OpJal    = 4'b0110;

  typedef struct packed {
    logic             valid;
    logic [OpW-1:0]   op;
    logic [RegAw-1:0] rd;
    logic             wr;
  } shadow_entry_t;

  typedef enum logic [1:0] {
    FwdRegfile = 2'b00,
    FwdEx      = 2'b01,
    FwdMe      = 2'b10,
    FwdWb      = 2'b11
  } fwd_sel_e;

  function automatic logic uses_rs2(input logic [OpW-1:0] op);
    return (op == OpAluR) || (op == OpCmpR) || (op == OpSw) || (op == OpBranch);
  endfunction

  function automatic logic uses_rs1(input logic [OpW-1:0] op);
    return uses_rs2(op) || (op == OpAluI) || (op == OpCmpI) || (op == OpLw) || (op == OpJal);
  endfunction

  function automatic logic is_writer(input logic [OpW-1:0] op);
    return (op != OpSw) && (op != OpBranch);
  endfunction

  // Youngest matching stage wins; match bit 0 is EX, 1 is ME, 2 is WB.
  function automatic fwd_sel_e fwd_pick(input logic [2:0] match);
    if (match[0]) return FwdEx;
    if (match[1]) return FwdMe;
    if (match[2]) return FwdWb;
    return FwdRegfile;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one DEC source register against the EX/ME/WB shadow entries.
module hazard_match #(
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0]      src,
  input  logic                   src_en,
  input  logic [2:0][REG_AW-1:0] ent_rd,
  input  logic [2:0]             ent_hit,
  output logic [2:0]             match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < 3; i++) begin
      match[i] = src_en && ent_hit[i] && (ent_rd[i] == src);
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler: shadow EX/ME/WB tracking, RAW stall, redirect flush, stall counter.
// Define HAZARD_FORWARD_EN to add forwarding selects and reduce stalls to load-use only.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [OP_W-1:0]   dec_op,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              ex_redirect,
  output logic              pc_stall,
  output logic              ifdec_stall,
  output logic              ifdec_flush,
  output logic              decex_bubble,
  output logic [CNT_W-1:0]  stall_cnt
`ifdef HAZARD_FORWARD_EN
  ,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel
`endif
);

  shadow_entry_t ex_q, me_q, wb_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [2:0][REG_AW-1:0] ent_rd;
  logic [2:0]             ent_hit;
  logic [2:0]             match_rs1, match_rs2;
  logic                   hazard;

  assign ent_rd = {wb_q.rd, me_q.rd, ex_q.rd};
  // Stored op is re-decoded alongside wr so only genuine writers can ever match.
  assign ent_hit = {wb_q.valid & wb_q.wr & is_writer(wb_q.op),
                    me_q.valid & me_q.wr & is_writer(me_q.op),
                    ex_q.valid & ex_q.wr & is_writer(ex_q.op)};

  hazard_match #(.REG_AW(REG_AW)) u_match_rs1 (
    .src     (dec_rs1),
    .src_en  (dec_valid & uses_rs1(dec_op)),
    .ent_rd  (ent_rd),
    .ent_hit (ent_hit),
    .match   (match_rs1)
  );

  hazard_match #(.REG_AW(REG_AW)) u_match_rs2 (
    .src     (dec_rs2),
    .src_en  (dec_valid & uses_rs2(dec_op)),
    .ent_rd  (ent_rd),
    .ent_hit (ent_hit),
    .match   (match_rs2)
  );

`ifdef HAZARD_FORWARD_EN
  assign hazard      = (match_rs1[0] | match_rs2[0]) & (ex_q.op == OpLw);
  assign fwd_rs1_sel = fwd_pick(match_rs1);
  assign fwd_rs2_sel = fwd_pick(match_rs2);
`else
  assign hazard = |{match_rs1, match_rs2};
`endif

  // Outputs are held low during reset regardless of ex_redirect.
  always_comb begin
    pc_stall     = 1'b0;
    ifdec_stall  = 1'b0;
    ifdec_flush  = 1'b0;
    decex_bubble = 1'b0;
    if (rst_n) begin
      if (ex_redirect) begin
        ifdec_flush  = 1'b1;
        decex_bubble = 1'b1;
      end else if (hazard) begin
        pc_stall     = 1'b1;
        ifdec_stall  = 1'b1;
        decex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    ex_d = '0;
    if (!(ex_redirect || hazard)) begin
      ex_d.valid = dec_valid;
      ex_d.op    = dec_op;
      ex_d.rd    = dec_rd;
      ex_d.wr    = dec_valid & is_writer(dec_op);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      me_q        <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      me_q <= ex_q;
      wb_q <= me_q;
      if (pc_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: RAW stalls, redirect flush, non-writers, reset, saturation.
module tb_hazard_sched;

  localparam logic [3:0] ALUR   = 4'b1100;
  localparam logic [3:0] ALUI   = 4'b0100;
  localparam logic [3:0] LW     = 4'b0111;
  localparam logic [3:0] SW     = 4'b0011;
  localparam logic [3:0] BRANCH = 4'b0010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dec_valid;
  logic [3:0] dec_op, dec_rd, dec_rs1, dec_rs2;
  logic       ex_redirect;

  logic        pc_stall, ifdec_stall, ifdec_flush, decex_bubble;
  logic [15:0] stall_cnt;
  logic        s_pc, s_ifs, s_fl, s_bb;
  logic [1:0]  s_cnt;
  logic [3:0]  outs;

  int checks = 0;
  int passes = 0;

  assign outs = {pc_stall, ifdec_stall, ifdec_flush, decex_bubble};

  always #5 clk = ~clk;

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd1, fwd2, s_fwd1, s_fwd2;
`endif

  hazard_sched #(.REG_AW(4), .OP_W(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dec_valid    (dec_valid),
    .dec_op       (dec_op),
    .dec_rd       (dec_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .ex_redirect  (ex_redirect),
    .pc_stall     (pc_stall),
    .ifdec_stall  (ifdec_stall),
    .ifdec_flush  (ifdec_flush),
    .decex_bubble (decex_bubble),
    .stall_cnt    (stall_cnt)
`ifdef HAZARD_FORWARD_EN
    ,
    .fwd_rs1_sel  (fwd1),
    .fwd_rs2_sel  (fwd2)
`endif
  );

  hazard_sched #(.REG_AW(4), .OP_W(4), .CNT_W(2)) dut_small (
    .clk          (clk),
    .rst_n        (rst_n),
    .dec_valid    (dec_valid),
    .dec_op       (dec_op),
    .dec_rd       (dec_rd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .ex_redirect  (ex_redirect),
    .pc_stall     (s_pc),
    .ifdec_stall  (s_ifs),
    .ifdec_flush  (s_fl),
    .decex_bubble (s_bb),
    .stall_cnt    (s_cnt)
`ifdef HAZARD_FORWARD_EN
    ,
    .fwd_rs1_sel  (s_fwd1),
    .fwd_rs2_sel  (s_fwd2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one DEC instruction for a cycle; outputs are then checked mid-low-phase.
  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic redir);
    @(negedge clk);
    dec_valid   = v;
    dec_op      = op;
    dec_rd      = rd;
    dec_rs1     = rs1;
    dec_rs2     = rs2;
    ex_redirect = redir;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    dec_valid   = 1'b1;
    dec_op      = ALUR;
    dec_rd      = 4'h1;
    dec_rs1     = 4'h1;
    dec_rs2     = 4'h1;
    ex_redirect = 1'b1;
    #3;
    chk("reset_outs_redirect_ignored", 32'(outs), 32'h0);
    chk("reset_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    ex_redirect = 1'b0;
    dec_valid   = 1'b0;

`ifdef HAZARD_FORWARD_EN
    drive(1'b1, ALUR, 4'd1, 4'd2, 4'd3, 1'b0);
    chk("fwd_prod_outs", 32'(outs), 32'h0);
    drive(1'b1, ALUR, 4'd2, 4'd1, 4'd3, 1'b0);
    chk("fwd_dep_no_stall", 32'(outs), 32'h0);
    chk("fwd_dep_rs1_ex", 32'(fwd1), 32'h1);
    chk("fwd_dep_rs2_rf", 32'(fwd2), 32'h0);
    idle(); idle(); idle();
    drive(1'b1, LW, 4'd4, 4'd0, 4'd0, 1'b0);
    chk("fwd_lw_outs", 32'(outs), 32'h0);
    drive(1'b1, ALUR, 4'd5, 4'd4, 4'd4, 1'b0);
    chk("fwd_loaduse_stall", 32'(outs), 32'hD);
    drive(1'b1, ALUR, 4'd5, 4'd4, 4'd4, 1'b0);
    chk("fwd_loaduse_release", 32'(outs), 32'h0);
    chk("fwd_loaduse_cnt", 32'(stall_cnt), 32'h1);
    chk("fwd_rs1_me", 32'(fwd1), 32'h2);
    chk("fwd_rs2_me", 32'(fwd2), 32'h2);
`else
    // Dependent ALU directly behind producer: three stall cycles.
    drive(1'b1, ALUR, 4'd1, 4'd2, 4'd3, 1'b0);
    chk("s1_prod_outs", 32'(outs), 32'h0);
    drive(1'b1, ALUR, 4'd2, 4'd1, 4'd3, 1'b0);
    chk("s1_stall_ex", 32'(outs), 32'hD);
    drive(1'b1, ALUR, 4'd2, 4'd1, 4'd3, 1'b0);
    chk("s1_stall_me", 32'(outs), 32'hD);
    chk("s1_cnt_1", 32'(stall_cnt), 32'h1);
    drive(1'b1, ALUR, 4'd2, 4'd1, 4'd3, 1'b0);
    chk("s1_stall_wb", 32'(outs), 32'hD);
    drive(1'b1, ALUR, 4'd2, 4'd1, 4'd3, 1'b0);
    chk("s1_release", 32'(outs), 32'h0);
    chk("s1_cnt_3", 32'(stall_cnt), 32'h3);
    chk("s1_small_cnt_3", 32'(s_cnt), 32'h3);
    idle(); idle(); idle();

    // Store depends on rs2; redirect overrides a hazarded DEC.
    drive(1'b1, ALUI, 4'd6, 4'd0, 4'd0, 1'b0);
    chk("s3_alui_outs", 32'(outs), 32'h0);
    drive(1'b1, SW, 4'd0, 4'd5, 4'd6, 1'b0);
    chk("s3_sw_rs2_stall", 32'(outs), 32'hD);
    drive(1'b1, SW, 4'd0, 4'd5, 4'd6, 1'b1);
    chk("s3_redirect_flush", 32'(outs), 32'h3);
    chk("s3_cnt_before", 32'(stall_cnt), 32'h4);
    idle();
    chk("s3_cnt_unchanged", 32'(stall_cnt), 32'h4);
    chk("s3_small_held", 32'(s_cnt), 32'h3);
    idle(); idle();

    // Unrelated sources and non-writers never stall.
    drive(1'b1, ALUR, 4'd7, 4'd0, 4'd0, 1'b0);
    drive(1'b1, SW, 4'd0, 4'd8, 4'd8, 1'b0);
    chk("s4_sw_r8", 32'(outs), 32'h0);
    drive(1'b1, BRANCH, 4'd0, 4'd8, 4'd8, 1'b0);
    chk("s4_branch_r8", 32'(outs), 32'h0);
    drive(1'b1, SW, 4'd9, 4'd10, 4'd10, 1'b0);
    chk("s4_sw_rd9", 32'(outs), 32'h0);
    drive(1'b1, ALUR, 4'd11, 4'd9, 4'd9, 1'b0);
    chk("s4_use_sw_rd", 32'(outs), 32'h0);
    drive(1'b1, ALUR, 4'd11, 4'd0, 4'd0, 1'b0);
    chk("s4_use_branch_rd", 32'(outs), 32'h0);
    idle(); idle(); idle();

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, LW, 4'd12, 4'd0, 4'd0, 1'b0);
    drive(1'b1, ALUR, 4'd13, 4'd12, 4'd1, 1'b0);
    chk("s5_stall", 32'(outs), 32'hD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_async_outs", 32'(outs), 32'h0);
    chk("s5_async_cnt", 32'(stall_cnt), 32'h0);
    chk("s5_async_small", 32'(s_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s5_release_no_stall", 32'(outs), 32'h0);

    // Two back-to-back dependency chains: 6 stalls, 2-bit counter saturates.
    drive(1'b1, ALUR, 4'd14, 4'd0, 4'd0, 1'b0);
    chk("s6_prod_outs", 32'(outs), 32'h0);
    drive(1'b1, ALUR, 4'd15, 4'd14, 4'd14, 1'b0);
    chk("s6_b_stall", 32'(outs), 32'hD);
    drive(1'b1, ALUR, 4'd15, 4'd14, 4'd14, 1'b0);
    chk("s6_small_1", 32'(s_cnt), 32'h1);
    drive(1'b1, ALUR, 4'd15, 4'd14, 4'd14, 1'b0);
    chk("s6_small_2", 32'(s_cnt), 32'h2);
    drive(1'b1, ALUR, 4'd15, 4'd14, 4'd14, 1'b0);
    chk("s6_b_release", 32'(outs), 32'h0);
    chk("s6_small_3", 32'(s_cnt), 32'h3);
    drive(1'b1, ALUR, 4'd2, 4'd15, 4'd15, 1'b0);
    chk("s6_c_stall", 32'(outs), 32'hD);
    drive(1'b1, ALUR, 4'd2, 4'd15, 4'd15, 1'b0);
    drive(1'b1, ALUR, 4'd2, 4'd15, 4'd15, 1'b0);
    drive(1'b1, ALUR, 4'd2, 4'd15, 4'd15, 1'b0);
    chk("s6_c_release", 32'(outs), 32'h0);
    chk("s6_cnt_6", 32'(stall_cnt), 32'h6);
    chk("s6_small_saturated", 32'(s_cnt), 32'h3);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
